sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 151 +++++++++++++++
 tb/tb_sram_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit load/store bridge onto a 16-bit asynchronous SRAM; optional macro SRAM_ADDR_CHECK_EN
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0]  LAST_CNT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE     = 32'(BASE_ADDR);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        is_wr;
  logic [16:0] idx;
  logic [31:0] wdata;
  logic [31:0] offset;
  logic        req;
  logic        last;
  logic        bad_req;

  assign req    = rd_en | wr_en;
  assign offset = address - BASE;
  assign last   = (cnt == LAST_CNT);

`ifdef SRAM_ADDR_CHECK_EN
  logic       bad;
  logic [1:0] unused_offset;

  // Below the data window, or beyond the 2^17-word SRAM, is rejected.
  assign bad_req       = (address < BASE) || (offset[31:19] != 13'd0);
  assign addr_err      = (state == DONE) && bad;
  assign unused_offset = offset[1:0];

  // Remember whether the accepted request was out of range.
  always_ff @(posedge clk) begin
    if (rst) begin
      bad <= 1'b0;
    end else if (state == IDLE && req) begin
      bad <= bad_req;
    end
  end
`else
  logic [14:0] unused_offset;

  // Without checking, the word index simply wraps modulo 2^17.
  assign bad_req       = 1'b0;
  assign addr_err      = 1'b0;
  assign unused_offset = {offset[31:19], offset[1:0]};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter restarts whenever the state changes, so LOW and HIGH each get WAIT_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (state != state_nxt) begin
      cnt <= 4'd0;
    end else if (state == LOW || state == HIGH) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Capture the request in IDLE; a simultaneous read and write is treated as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr <= 1'b0;
      idx   <= 17'd0;
      wdata <= 32'd0;
    end else if (state == IDLE && req) begin
      is_wr <= wr_en;
      idx   <= offset[18:2];
      wdata <= write_data;
    end
  end

  // Sample each read half on the final cycle of its phase, when the SRAM data has settled longest.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= 32'd0;
    end else if (!is_wr && last) begin
      if (state == LOW) begin
        read_data[15:0] <= sram_dq_in;
      end else if (state == HIGH) begin
        read_data[31:16] <= sram_dq_in;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = bad_req ? DONE : LOW;
      LOW:  if (last) state_nxt = HIGH;
      HIGH: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes and bus are decoded from the registered state so they stay glitch-free per phase.
  always_comb begin
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = 16'd0;
    sram_addr   = 18'd0;
    if (state == LOW || state == HIGH) begin
      sram_ce_n = 1'b0;
      sram_addr = {idx, (state == HIGH)};
      if (is_wr) begin
        sram_we_n   = 1'b0;
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HIGH) ? wdata[31:16] : wdata[15:0];
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ready = (state == DONE) || (state == IDLE && !req);

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller with a behavioural SRAM
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        addr_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  logic [15:0] mem [0:262143];

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .addr_err(addr_err), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous-looking write, combinational read.
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request (cycle 1), drop it after acceptance, and count cycles until ready.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, output int cyc);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    cyc = 1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    cyc = 2;
    #1;
    while (ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", ready, 1);
    check("rst_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_read_data", read_data, 0);
    check("rst_addr_err", addr_err, 0);

    // Write 0xDEADBEEF to byte 1028 -> halfwords 2 and 3.
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEADBEEF;
    #1;
    check("wr_req_ready", ready, 0);
    tick(); wr_en = 1'b0;
    check("wr_c2_addr", sram_addr, 18'd2);
    check("wr_c2_dq", sram_dq_out, 16'hBEEF);
    check("wr_c2_strb", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 4'b0011);
    tick();
    check("wr_c3_addr", sram_addr, 18'd2);
    check("wr_c3_dq", sram_dq_out, 16'hBEEF);
    tick();
    check("wr_c4_addr", sram_addr, 18'd3);
    check("wr_c4_dq", sram_dq_out, 16'hDEAD);
    tick();
    check("wr_c5_addr", sram_addr, 18'd3);
    check("wr_c5_ready", ready, 0);
    tick();
    check("wr_c6_ready", ready, 1);
    check("wr_c6_strb", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 4'b1110);
    tick();

    // Read it back.
    run_access(1'b0, 1'b1, 32'd1028, 32'd0, lat);
    check("rd_latency", lat, 6);
    check("rd_data", read_data, 32'hDEADBEEF);
    tick();
    check("rd_hold", read_data, 32'hDEADBEEF);

    // Back-to-back write then read at 1032 with no idle gap.
    run_access(1'b1, 1'b0, 32'd1032, 32'hCAFE0123, lat);
    check("b2b_wr_latency", lat, 6);
    rd_en = 1'b1; address = 32'd1032;
    tick(); lat++;
    check("b2b_gap_ready", ready, 0);
    tick(); lat++;
    rd_en = 1'b0;
    check("b2b_rd_addr", sram_addr, 18'd4);
    check("b2b_rd_oe_n", sram_oe_n, 0);
    while (ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("b2b_total", lat, 12);
    check("b2b_rd_data", read_data, 32'hCAFE0123);
    tick();

    // rd_en and wr_en together behave as a write.
    wr_en = 1'b1; rd_en = 1'b1; address = 32'd1040; write_data = 32'h0BADF00D;
    tick(); wr_en = 1'b0; rd_en = 1'b0;
    check("both_strb", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 4'b0011);
    check("both_dq", sram_dq_out, 16'hF00D);
    lat = 2;
    while (ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("both_latency", lat, 6);
    check("both_rd_unchanged", read_data, 32'hCAFE0123);
    tick();
    run_access(1'b0, 1'b1, 32'd1040, 32'd0, lat);
    check("both_readback", read_data, 32'h0BADF00D);
    tick();

    // Reset asserted during HIGH of a write.
    wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
    tick(); wr_en = 1'b0;
    tick();
    tick();
    check("mid_high_addr", sram_addr, 18'd7);
    check("mid_high_we_n", sram_we_n, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_strb", {sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 4'b1110);
    check("mid_rst_addr", sram_addr, 0);
    check("mid_rst_rdata", read_data, 0);
    tick();
    check("post_rst_ready", ready, 1);

    // Address below BASE_ADDR.
`ifdef SRAM_ADDR_CHECK_EN
    run_access(1'b1, 1'b0, 32'd512, 32'h56781234, lat);
    check("oor_wr_latency", lat, 2);
    check("oor_wr_err", addr_err, 1);
    check("oor_wr_strb", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
    tick();
    check("oor_err_pulse", addr_err, 0);
    run_access(1'b0, 1'b1, 32'd512, 32'd0, lat);
    check("oor_rd_latency", lat, 2);
    check("oor_rd_err", addr_err, 1);
    check("oor_rd_unchanged", read_data, 0);
    tick();
`else
    run_access(1'b1, 1'b0, 32'd512, 32'h56781234, lat);
    check("wrap_wr_latency", lat, 6);
    tick();
    rd_en = 1'b1; address = 32'd512;
    tick(); rd_en = 1'b0;
    check("wrap_addr_low", sram_addr, 18'h3FF00);
    check("wrap_err", addr_err, 0);
    lat = 2;
    while (ready !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("wrap_rd_latency", lat, 6);
    check("wrap_rd_data", read_data, 32'h56781234);
    check("wrap_done_err", addr_err, 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
